// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants shared by the BCD encoder and the capture block.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef struct packed {
        logic       illegal;
        logic [3:0] bcd;
    } seg7_dec_t;

endpackage

// File: rtl/sev_seg_capture_if.sv
// Seven-segment bus as seen by the capture block, plus its recovered digits.
// The master side drives the display lines; the slave side captures them.
interface sev_seg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              SevenSegs;
    logic [NUM_DIGITS-1:0]   AnIn;
    logic [4*NUM_DIGITS-1:0] BCD;
    logic [NUM_DIGITS-1:0]   DigitErr;
    logic                    Update;
    logic                    Overlap;

    modport master (
        output SevenSegs, AnIn,
        input  BCD, DigitErr, Update, Overlap
    );

    modport slave (
        input  SevenSegs, AnIn,
        output BCD, DigitErr, Update, Overlap
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decode.
// Blank decodes to BCD_BLANK; anything outside the table is flagged illegal.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output seg7_dec_t  o_dec
);

    always_comb begin
        o_dec.illegal = 1'b0;
        o_dec.bcd     = BCD_BLANK;
        case (i_pat)
            SEG_0:     o_dec.bcd = 4'd0;
            SEG_1:     o_dec.bcd = 4'd1;
            SEG_2:     o_dec.bcd = 4'd2;
            SEG_3:     o_dec.bcd = 4'd3;
            SEG_4:     o_dec.bcd = 4'd4;
            SEG_5:     o_dec.bcd = 4'd5;
            SEG_6:     o_dec.bcd = 4'd6;
            SEG_7:     o_dec.bcd = 4'd7;
            SEG_8:     o_dec.bcd = 4'd8;
            SEG_9:     o_dec.bcd = 4'd9;
            SEG_BLANK: o_dec.bcd = BCD_BLANK;
            default:   o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sev_seg_capture.sv
// Recovers per-digit BCD values from a multiplexed seven-segment bus,
// committing a digit only after its pattern has been stable long enough.
module sev_seg_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              Clk,
    input logic              Rst,
    sev_seg_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [6:0] SEG_IDLE_RAW = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0]            r_seg_s1;
    logic [6:0]            r_seg_s2;
    logic [NUM_DIGITS-1:0] r_an_s1;
    logic [NUM_DIGITS-1:0] r_an_s2;
    logic [NUM_DIGITS-1:0] r_q_sel;
    logic [6:0]            r_q_pat;
    logic                  r_overlap;
    logic                  r_update;
    logic [NUM_DIGITS-1:0] w_act;
    logic [NUM_DIGITS-1:0] w_cmt;
    logic                  w_multi;

    // s2 already holds the active-high pattern
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_seg_s1 <= SEG_IDLE_RAW;
            r_seg_s2 <= SEG_BLANK;
            r_an_s1  <= '1;
            r_an_s2  <= '1;
        end else begin
            r_seg_s1 <= bus.SevenSegs;
            r_seg_s2 <= SEG_ACTIVE_LOW ? ~r_seg_s1 : r_seg_s1;
            r_an_s1  <= bus.AnIn;
            r_an_s2  <= r_an_s1;
        end
    end

    assign w_act   = ~r_an_s2;
    assign w_multi = (w_act & (w_act - NUM_DIGITS'(1))) != '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q_sel   <= '0;
            r_q_pat   <= SEG_BLANK;
            r_overlap <= 1'b0;
        end else begin
            r_q_sel   <= w_multi ? '0 : w_act;
            r_q_pat   <= r_seg_s2;
            r_overlap <= w_multi;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [CW-1:0] r_cnt;
        logic [6:0]    r_last;
        logic          r_cmt;
        logic [3:0]    r_bcd;
        logic          r_err;
        seg7_dec_t     w_dec;

        seg7_decode u_dec (
            .i_pat (r_last),
            .o_dec (w_dec)
        );

        // r_last still holds the committed pattern on the edge after r_cmt
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_cnt  <= '0;
                r_last <= SEG_BLANK;
                r_cmt  <= 1'b0;
                r_bcd  <= BCD_BLANK;
                r_err  <= 1'b0;
            end else begin
                r_cmt <= 1'b0;
                if (r_cmt) begin
                    r_err <= w_dec.illegal;
                    if (!w_dec.illegal) begin
                        r_bcd <= w_dec.bcd;
                    end
                end
                if (r_q_sel[i]) begin
                    if (r_q_pat != r_last) begin
                        r_last <= r_q_pat;
                        r_cnt  <= CW'(1);
                        r_cmt  <= (STABLE_CYCLES == 1);
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                        r_cmt <= (r_cnt == CNT_MAX - CW'(1));
                    end
                end
            end
        end

        assign w_cmt[i]          = r_cmt;
        assign bus.BCD[4*i +: 4] = r_bcd;
        assign bus.DigitErr[i]   = r_err;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_update <= 1'b0;
        end else begin
            r_update <= |w_cmt;
        end
    end

    assign bus.Update  = r_update;
    assign bus.Overlap = r_overlap;

endmodule

// File: doc/sev_seg_capture.md
Name: sev_seg_capture

Overview:
- Receive side of the seven-segment display interface. It is the counterpart to the team's BCD-to-seven-segment encoder.
- Watches an external, time-multiplexed seven-segment bus (segment lines plus active-low anode selects) and recovers the BCD digit shown on each position.
- Only latches a digit after its pattern has been stable for a programmable number of selected cycles.
- Used for loopback self-test of the display path and for reading displays on attached boards.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (anode lines); legal range 1..8.
- STABLE_CYCLES, 16: consecutive selected, identical samples required before a digit is committed; minimum 1, counter width clog2(STABLE_CYCLES+1).
- SEG_ACTIVE_LOW, 1: 1 = segment line low means lit; input is inverted after synchronisation so internal patterns are active-high.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous, active-high reset.
- SevenSegs  input  7  segment lines {g,f,e,d,c,b,a}, asynchronous to Clk.
- AnIn  input  NUM_DIGITS  anode selects, active-low, asynchronous to Clk; bit i selects digit i.
- BCD  output  4*NUM_DIGITS  committed digit values; digit i in bits [4i+3:4i]; 4'hF = blank.
- DigitErr  output  NUM_DIGITS  bit i = last committed pattern on digit i was illegal.
- Update  output  1  one-cycle pulse on any commit.
- Overlap  output  1  one-cycle pulse when a sample had more than one anode active.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset values:
  - BCD = all 4'hF; DigitErr = 0; Update = 0; Overlap = 0.
  - All stability counters = 0.
  - Per-digit last-sample registers = 7'h00 (blank).
- Input synchronisation:
  - SevenSegs and AnIn each pass through a 2-flop synchroniser (s1, s2).
  - Polarity correction is applied at s2.
- Sample qualification, from s2 at each edge:
  - Zero anodes active: no state change.
  - Exactly one anode i active: the sample belongs to digit i.
  - Two or more active: sample discarded, no counter or register change, Overlap high next cycle.
- Stability counter, per digit i, on a qualified sample:
  - Pattern equals last-sample[i]: counter increments, saturating at STABLE_CYCLES.
  - Pattern differs: last-sample[i] := pattern and counter := 1.
  - Deselected digits retain both counter and last-sample.
- Commit:
  - Occurs on the edge where counter[i] transitions to STABLE_CYCLES (exactly once per stable episode; saturation does not recommit).
  - On the following edge: BCD[i] := decoded value, DigitErr[i] := illegal flag, and Update is high for that one cycle.
- Decode table (active-high hex → BCD): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 00→F (blank, not an error).
- Illegal patterns: any other pattern commits with BCD[i] unchanged and DigitErr[i] = 1. A later legal commit clears DigitErr[i].
- Latency: with constant inputs and digit always selected, the input is applied before edge 0, the first counted sample lands at edge 3, and outputs change after edge 3+STABLE_CYCLES.
- STABLE_CYCLES = 1: every pattern change commits on the next edge.
- Simultaneous commits on different digits in the same cycle: all are applied; a single Update pulse.
- Rst mid-episode: all state returns to reset values on that edge, and the synchroniser flops are cleared to the inactive level. No commit or Update fires from pre-reset samples.
- Glitch during the stable run (one differing sample): counter restarts at 1 and no commit occurs.

Decomposition:
- Shared package seg7_pkg:
  - Ten digit pattern constants plus SEG_BLANK (7'h00), shared with the BCD-to-seven-segment encoder so the two ends cannot diverge.
  - BCD_BLANK = 4'hF.
- One natural sub-module: seg7_decode, a registered-free decode of 7-bit pattern → {illegal, bcd[3:0]}.
- The per-digit counter/last-sample logic is a generate loop in the top.

Test Plan:
- Reset, then idle bus (AnIn all 1) → BCD = FFFF, DigitErr = 0, no Update for 100 cycles.
- STABLE_CYCLES=4, AnIn=4'b1110, SevenSegs active-low ~7'h5B held → BCD[3:0]=2 after edge 7, single Update pulse, no further pulses while held.
- Scan AnIn 1110/1101/1011/0111 every 8 cycles showing 1, 2, 3, 4 (STABLE_CYCLES=4) → BCD=16'h4321 within two scan rounds, DigitErr=0.
- Digit 1 shows illegal 7'h49 (active-high) stable → DigitErr[1]=1, BCD[7:4] retains previous value; then 7'h3F stable → BCD[7:4]=0, DigitErr[1]=0.
- Pattern 7F held 3 samples, then one 6F sample, then 7F (STABLE_CYCLES=4) → no commit until 4 consecutive 7F, then BCD digit = 8.
- AnIn=4'b1100 for 5 cycles → Overlap pulses per sample, counters unchanged; assert Rst at counter=3 → outputs stay at reset values, no Update.
